// File: rtl/bus_xcvr_seq_if.sv
// Host/transceiver signal bundle for bus_xcvr_seq.
// The slave modport is the sequencer; the master modport is the host plus
// the A-side bus that supplies a_in.
interface bus_xcvr_seq_if;
  logic       req;
  logic       we;
  logic [7:0] wdata;
  logic [7:0] a_in;
  logic       dir;
  logic       oe;
  logic [7:0] a_out;
  logic       a_oe;
  logic [7:0] rdata;
  logic       ack;
  logic       busy;

  modport master (
    output req, we, wdata, a_in,
    input  dir, oe, a_out, a_oe, rdata, ack, busy
  );

  modport slave (
    input  req, we, wdata, a_in,
    output dir, oe, a_out, a_oe, rdata, ack, busy
  );
endinterface

// File: rtl/bus_xcvr_seq.sv
// Bus transceiver sequencer: steps an external bidirectional transceiver
// through SETUP -> STROBE -> TURN for each host transaction, with dir only
// ever changing while the transceiver is disabled (oe=1).
module bus_xcvr_seq #(
  parameter int unsigned STROBE_CYCLES = 2,  // 1..15
  parameter int unsigned TURN_CYCLES   = 1   // 1..15
) (
  input  logic           clk,
  input  logic           reset,
  bus_xcvr_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    TURN
  } state_t;

  // Counter is loaded with N-1 on entry and the phase ends when it reads 0.
  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] TURN_LOAD   = 4'(TURN_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       we_q;
  logic       dir_q;
  logic       oe_q;
  logic [7:0] a_out_q;
  logic       a_oe_q;
  logic [7:0] rdata_q;
  logic       ack_q;
  logic       busy_q;

  // Sequencer FSM with all outputs registered; ack is a one-cycle pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      dir_q   <= 1'b0;
      oe_q    <= 1'b1;
      a_out_q <= '0;
      a_oe_q  <= 1'b0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      unique case (state)
        IDLE: begin
          // The ack cycle is an IDLE cycle, so a req here chains directly.
          if (bus.req) begin
            state   <= SETUP;
            cnt     <= '0;
            we_q    <= bus.we;
            dir_q   <= bus.we;
            a_oe_q  <= bus.we;
            a_out_q <= bus.wdata;
            oe_q    <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        SETUP: begin
          state <= STROBE;
          cnt   <= STROBE_LOAD;
          oe_q  <= 1'b0;
        end
        STROBE: begin
          if (cnt == '0) begin
            state  <= TURN;
            cnt    <= TURN_LOAD;
            oe_q   <= 1'b1;
            a_oe_q <= 1'b0;
            if (!we_q) begin
              rdata_q <= bus.a_in;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        TURN: begin
          if (cnt == '0) begin
            state  <= IDLE;
            cnt    <= '0;
            ack_q  <= 1'b1;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.dir   = dir_q;
  assign bus.oe    = oe_q;
  assign bus.a_out = a_out_q;
  assign bus.a_oe  = a_oe_q;
  assign bus.rdata = rdata_q;
  assign bus.ack   = ack_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_bus_xcvr_seq.sv
// Testbench for bus_xcvr_seq: directed transactions on a default instance
// and a long-timing instance; ack responses checked against a queue.
module tb_bus_xcvr_seq;
  localparam int S0 = 2;
  localparam int T0 = 1;
  localparam int S1 = 15;
  localparam int T1 = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bus_xcvr_seq_if b0 ();
  bus_xcvr_seq_if b1 ();

  bus_xcvr_seq #(.STROBE_CYCLES(S0), .TURN_CYCLES(T0)) dut0 (
    .clk(clk), .reset(reset), .bus(b0.slave)
  );
  bus_xcvr_seq #(.STROBE_CYCLES(S1), .TURN_CYCLES(T1)) dut1 (
    .clk(clk), .reset(reset), .bus(b1.slave)
  );

  typedef struct {
    int         ack_cyc;
    logic [7:0] rdata;
    logic [7:0] a_out;
    int         oe_low;
    logic       dir;
  } exp_t;

  exp_t       q0[$];
  exp_t       q1[$];
  int         cyc = 0;
  int         nerr = 0;
  int         nchk = 0;
  logic [7:0] rmodel = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk1(input string n, input logic a, input logic e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %b, want %b (cycle %0d)", n, a, e, cyc);
    end
  endtask

  task automatic chk8(input string n, input logic [7:0] a, input logic [7:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got 0x%02h, want 0x%02h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  task automatic chki(input string n, input int a, input int e);
    nchk++;
    if (a != e) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", n, a, e, cyc);
    end
  endtask

  task automatic check_ack(input string tag, input exp_t e, input logic [7:0] rd,
                           input logic [7:0] ao, input int low, input logic d,
                           input logic bsy);
    chki({tag, ".ack_cycle"}, cyc, e.ack_cyc);
    chk8({tag, ".rdata"}, rd, e.rdata);
    chk8({tag, ".a_out"}, ao, e.a_out);
    chki({tag, ".oe_low_cycles"}, low, e.oe_low);
    chk1({tag, ".dir_hold"}, d, e.dir);
    chk1({tag, ".busy_at_ack"}, bsy, 1'b0);
  endtask

  // Monitor: counts strobe length, checks bus-safety invariants, pops on ack.
  int   low0 = 0;
  int   low1 = 0;
  logic pdir0 = 1'b0, poe0 = 1'b1, pdir1 = 1'b0, poe1 = 1'b1;
  always @(negedge clk) begin
    if (reset !== 1'b0) begin
      low0 = 0;
      low1 = 0;
    end else begin
      if (!b0.oe) begin
        low0++;
        chk1("contention0", b0.a_oe & ~b0.dir, 1'b0);
      end
      if (!b1.oe) begin
        low1++;
        chk1("contention1", b1.a_oe & ~b1.dir, 1'b0);
      end
      if (b0.dir !== pdir0) chk1("dir_change_with_oe0", poe0 & b0.oe, 1'b1);
      if (b1.dir !== pdir1) chk1("dir_change_with_oe1", poe1 & b1.oe, 1'b1);
      if (b0.ack) begin
        if (q0.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL unexpected_ack0: got ack=1, want no ack (cycle %0d)", cyc);
        end else begin
          check_ack("dut0", q0.pop_front(), b0.rdata, b0.a_out, low0, b0.dir, b0.busy);
        end
        low0 = 0;
      end
      if (b1.ack) begin
        if (q1.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL unexpected_ack1: got ack=1, want no ack (cycle %0d)", cyc);
        end else begin
          check_ack("dut1", q1.pop_front(), b1.rdata, b1.a_out, low1, b1.dir, b1.busy);
        end
        low1 = 0;
      end
    end
    pdir0 = b0.dir; poe0 = b0.oe;
    pdir1 = b1.dir; poe1 = b1.oe;
  end

  // One full transaction on dut0, returning at the last TURN cycle so a
  // following call lands its request in the ack cycle.
  task automatic run_txn(input logic w, input logic [7:0] d, input logic [7:0] ain,
                         input bit pulse, input bit rel_reset, input string tag);
    exp_t       e;
    int         t0;
    logic [7:0] rexp;
    @(negedge clk);
    if (rel_reset) reset = 1'b0;
    b0.req = 1'b1; b0.we = w; b0.wdata = d; b0.a_in = ~ain;
    t0 = cyc + 1;
    rexp = w ? rmodel : ain;
    e = '{t0 + 1 + S0 + T0, rexp, d, S0, w};
    q0.push_back(e);
    @(negedge clk);
    b0.req = 1'b0; b0.we = ~w; b0.wdata = ~d;
    chk1({tag, ".setup_dir"}, b0.dir, w);
    chk1({tag, ".setup_a_oe"}, b0.a_oe, w);
    chk1({tag, ".setup_oe"}, b0.oe, 1'b1);
    chk1({tag, ".setup_busy"}, b0.busy, 1'b1);
    chk8({tag, ".setup_a_out"}, b0.a_out, d);
    for (int k = 2; k <= 1 + S0; k++) begin
      @(negedge clk);
      b0.req = pulse && (k == 2);
      if (pulse && k == 2) b0.wdata = 8'hFF;
      b0.a_in = (k == 1 + S0) ? ain : ~ain;
      chk1({tag, ".strobe_oe"}, b0.oe, 1'b0);
      chk1({tag, ".strobe_dir"}, b0.dir, w);
      chk1({tag, ".strobe_a_oe"}, b0.a_oe, w);
      chk8({tag, ".strobe_a_out"}, b0.a_out, d);
      chk8({tag, ".strobe_rdata"}, b0.rdata, rmodel);
    end
    rmodel = rexp;
    for (int k = 0; k < T0; k++) begin
      @(negedge clk);
      b0.req = 1'b0; b0.a_in = ~ain;
      chk1({tag, ".turn_oe"}, b0.oe, 1'b1);
      chk1({tag, ".turn_a_oe"}, b0.a_oe, 1'b0);
      chk1({tag, ".turn_busy"}, b0.busy, 1'b1);
      chk1({tag, ".turn_ack"}, b0.ack, 1'b0);
      chk8({tag, ".turn_rdata"}, b0.rdata, rmodel);
    end
  endtask

  task automatic idle(input int n, input logic d);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      b0.req = 1'b0;
      chk1("idle_busy", b0.busy, 1'b0);
      chk1("idle_oe", b0.oe, 1'b1);
      chk1("idle_a_oe", b0.a_oe, 1'b0);
      chk1("idle_dir_retained", b0.dir, d);
    end
  endtask

  initial begin
    exp_t e1;
    int   t1;
    b0.req = 1'b0; b0.we = 1'b0; b0.wdata = 8'h00; b0.a_in = 8'h00;
    b1.req = 1'b0; b1.we = 1'b0; b1.wdata = 8'h00; b1.a_in = 8'h77;
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk1("rst_dir", b0.dir, 1'b0);
    chk1("rst_oe", b0.oe, 1'b1);
    chk1("rst_a_oe", b0.a_oe, 1'b0);
    chk8("rst_a_out", b0.a_out, 8'h00);
    chk8("rst_rdata", b0.rdata, 8'h00);
    chk1("rst_ack", b0.ack, 1'b0);
    chk1("rst_busy", b0.busy, 1'b0);
    chk1("rst_busy1", b1.busy, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle(2, 1'b0);

    run_txn(1'b1, 8'hA5, 8'h00, 1'b0, 1'b0, "wr_a5");
    idle(3, 1'b1);
    run_txn(1'b0, 8'h00, 8'h3C, 1'b0, 1'b0, "rd_3c");
    idle(2, 1'b0);
    run_txn(1'b1, 8'h11, 8'h00, 1'b0, 1'b0, "b2b_wr");
    run_txn(1'b0, 8'h22, 8'h96, 1'b0, 1'b0, "b2b_rd");
    idle(2, 1'b0);
    run_txn(1'b1, 8'h5C, 8'h00, 1'b1, 1'b0, "ign_busy");
    idle(1, 1'b1);

    // Abort a write mid-STROBE with an asynchronous reset.
    @(negedge clk);
    b0.req = 1'b1; b0.we = 1'b1; b0.wdata = 8'hC3;
    @(negedge clk);
    b0.req = 1'b0;
    @(negedge clk);
    chk1("abort_pre_oe", b0.oe, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk1("abort_oe", b0.oe, 1'b1);
    chk1("abort_a_oe", b0.a_oe, 1'b0);
    chk1("abort_busy", b0.busy, 1'b0);
    chk1("abort_dir", b0.dir, 1'b0);
    chk8("abort_a_out", b0.a_out, 8'h00);
    chk8("abort_rdata", b0.rdata, 8'h00);
    rmodel = 8'h00;
    repeat (3) @(negedge clk);
    run_txn(1'b1, 8'h42, 8'h00, 1'b0, 1'b1, "post_rst");
    idle(3, 1'b1);

    // Long strobe/turn instance: a read with a_in held at 0x77.
    @(negedge clk);
    b1.req = 1'b1; b1.we = 1'b0; b1.wdata = 8'h5A;
    t1 = cyc + 1;
    e1 = '{t1 + 1 + S1 + T1, 8'h77, 8'h5A, S1, 1'b0};
    q1.push_back(e1);
    @(negedge clk);
    b1.req = 1'b0;

    for (int i = 0; i < 60 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    while (q0.size() != 0) begin
      void'(q0.pop_front());
      nchk++; nerr++;
      $display("FAIL ack_timeout0: got no ack, want ack within budget");
    end
    while (q1.size() != 0) begin
      void'(q1.pop_front());
      nchk++; nerr++;
      $display("FAIL ack_timeout1: got no ack, want ack within budget");
    end
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/bus_xcvr_seq.md
BUS_XCVR_SEQ -- requirements
Module: bus_xcvr_seq

Interface
REQ-001 Parameter STROBE_CYCLES, default 2, number of cycles the transceiver is enabled per transaction; legal range 1..15.
REQ-002 Parameter TURN_CYCLES, default 1, bus turnaround cycles with the transceiver disabled after each strobe; legal range 1..15.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 req  in  1  host transaction request, sampled when busy=0.
REQ-007 we  in  1  1=write (A side to B side), 0=read (B side to A side); sampled with req.
REQ-008 wdata  in  8  write data, sampled with req.
REQ-009 a_in  in  8  A-side bus value, sampled for reads.
REQ-010 dir  out  1  to transceiver DIR; 1=A drives B.
REQ-011 oe  out  1  to transceiver OE, active-low; 1=transceiver disabled.
REQ-012 a_out  out  8  data this block drives onto the A side.
REQ-013 a_oe  out  1  1=this block drives a_out onto the A side.
REQ-014 rdata  out  8  captured read data.
REQ-015 ack  out  1  one-cycle completion pulse.
REQ-016 busy  out  1  1 while a transaction is in progress.

Function
REQ-017 The FSM SHALL have the states IDLE, SETUP, STROBE, TURN; all outputs SHALL be registered.
REQ-018 IDLE: busy=0 and oe=1; if req=1 at a rising edge, latch we/wdata and go to SETUP, otherwise stay in IDLE.
REQ-019 SETUP (1 cycle): dir=latched we, oe=1, a_oe=we, a_out=wdata; then go to STROBE.
REQ-020 STROBE (STROBE_CYCLES cycles): oe=0; dir and a_oe SHALL hold their SETUP values.
REQ-021 On a read, rdata SHALL load a_in at the clock edge that ends the last STROBE cycle.
REQ-022 On a write, rdata SHALL remain unchanged.
REQ-023 TURN (TURN_CYCLES cycles): oe=1, a_oe=0; then go to IDLE with ack=1 for exactly one cycle.
REQ-024 busy SHALL be 1 in SETUP, STROBE and TURN, and 0 in IDLE, including the ack cycle.
REQ-025 dir SHALL change only while oe=1.
REQ-026 a_oe=1 and dir=0 SHALL never occur together while oe=0, so no bus contention occurs.
REQ-027 dir SHALL retain its last value in IDLE.
REQ-028 req while busy=0 in the ack cycle SHALL be accepted, giving back-to-back transactions with no idle gap.
REQ-029 req while busy=1 SHALL be ignored; we and wdata changes while busy=1 SHALL have no effect.
REQ-030 Latency: with req sampled at the edge ending cycle 0, SETUP=cycle 1, STROBE=cycles 2..1+S, TURN=cycles 2+S..1+S+T, ack=cycle 2+S+T.
REQ-031 A single 4-bit down-counter SHALL time STROBE and TURN; it SHALL reload on every state entry.

Reset
REQ-032 On reset assertion, regardless of the clock, the block SHALL force state=IDLE, dir=0, oe=1, a_oe=0, a_out=0x00, rdata=0x00, ack=0, busy=0, counter=0.
REQ-033 Reset asserted mid-transaction SHALL abort it with no ack.
REQ-034 The first req SHALL be honoured at the first rising edge after reset deasserts.

Verification
REQ-035 Reset: assert reset mid-STROBE of a write -> oe=1, a_oe=0, busy=0 asynchronously, and no ack follows.
REQ-036 Write, defaults: req=1, we=1, wdata=0xA5 in cycle 0 -> dir=1 and a_oe=1 from cycle 1; a_out=0xA5; oe=0 in cycles 2-3; TURN in cycle 4; ack=1 only in cycle 5.
REQ-037 Read, defaults: req=1, we=0 in cycle 0; a_in=0x3C during cycle 3 -> dir=0 and a_oe=0 throughout; oe=0 in cycles 2-3; rdata=0x3C in cycle 4; ack in cycle 5.
REQ-038 Back-to-back: write 0x11, then req held high for a read -> second SETUP in the cycle after ack; dir flips 1->0 only with oe=1.
REQ-039 Ignore while busy: pulse req with wdata=0xFF during STROBE -> no effect; a_out stays at the original value; exactly one ack.
REQ-040 Parameters: STROBE_CYCLES=15, TURN_CYCLES=3 -> oe=0 for exactly 15 cycles; ack 19 cycles after the req edge.
